mem_bus_monitor: RTL

MEM_BUS_MONITOR -- requirements
Module: mem_bus_monitor

---
 rtl/mon_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 59 +++++
 rtl/mem_bus_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mon_pkg.sv
// Shared types and constants for the memory bus monitor.
// No timing of its own; pure declarations.
// No flow control involved.
package mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HANG = 2'd3
  } mon_state_e;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Saturating increment: the counters stick at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO holding traced write transactions.
// Latency: push visible at the head one cycle later.
// Backpressure: none; a push into a full buffer is dropped and flagged unless a pop frees the slot.
module trace_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         vld_o,
  output logic [W-1:0] dout_o,
  output logic         ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, full, do_push, do_pop;

  // The extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;
  assign vld_o   = !empty;
  // Head is forced to zero when empty so a reset buffer shows no stale data.
  assign dout_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; clearing them discards all buffered entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mem_bus_monitor.sv
// Passive monitor of a processor memory bus: counts, traces and checks transactions, detects end/hang.
// Latency: status and counters update one cycle after the observed strobe.
// Backpressure: none toward the bus; trace entries are lost (overflow flagged) when the buffer is full.
module mem_bus_monitor
  import mon_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] mar,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  input  logic             kraj,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             trace_rd,
  output logic             trace_valid,
  output logic [WIDTH-1:0] trace_addr,
  output logic [WIDTH-1:0] trace_data,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count,
  output logic [WIDTH-1:0] last_rdata,
  output logic             mismatch,
  output logic             overflow,
  output logic             done,
  output logic             timeout
);

  localparam int             IW        = $clog2(TIMEOUT);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

  mon_state_e       state_q, state_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [WIDTH-1:0] last_rdata_q, last_rdata_d;
  logic             mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic             active, strobe, trace_push, fifo_ovf;
  logic [2*WIDTH-1:0] trace_dout;

  // Only IDLE and RUN observe the bus, including the cycle kraj arrives.
  assign active     = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign strobe     = memread || memwrite;
  assign trace_push = active && memwrite;
  assign overflow_d = overflow_q || fifo_ovf;

  // FSM next-state, idle counter, counters and compare.
  always_comb begin
    state_d      = state_q;
    idle_d       = idle_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    last_rdata_d = last_rdata_q;
    mismatch_d   = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (kraj)        state_d = ST_DONE;
        else if (strobe) state_d = ST_RUN;
      end
      ST_RUN: begin
        // kraj takes priority over a simultaneous idle expiry.
        if (kraj)                     state_d = ST_DONE;
        else if (strobe)              idle_d  = '0;
        else if (idle_q == IDLE_LAST) state_d = ST_HANG;
        else                          idle_d  = idle_q + 1'b1;
      end
      default: ;
    endcase
    if (active) begin
      if (memread) begin
        rd_cnt_d     = sat_inc(rd_cnt_q);
        last_rdata_d = memdata;
      end
      if (memwrite) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
        if (exp_valid && ((mar != exp_addr) || (writedata != exp_data))) mismatch_d = 1'b1;
      end
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idle_q       <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      last_rdata_q <= '0;
      mismatch_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      last_rdata_q <= last_rdata_d;
      mismatch_q   <= mismatch_d;
      overflow_q   <= overflow_d;
    end
  end

  trace_fifo #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (trace_push),
    .din_i  ({mar, writedata}),
    .pop_i  (trace_rd),
    .vld_o  (trace_valid),
    .dout_o (trace_dout),
    .ovf_o  (fifo_ovf)
  );

  assign trace_addr = trace_dout[2*WIDTH-1:WIDTH];
  assign trace_data = trace_dout[WIDTH-1:0];
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
  assign last_rdata = last_rdata_q;
  assign mismatch   = mismatch_q;
  assign overflow   = overflow_q;
  // Terminal states make these flags sticky until reset.
  assign done       = (state_q == ST_DONE);
  assign timeout    = (state_q == ST_HANG);

endmodule
